// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_port_pkg
// Description : Shared constants for the processor I/O bridge. Holds the
//               default data width and FIFO depth, and the bit positions of
//               the sticky error flags.
// Revision    : 1.0  initial release
// ============================================================================
package io_port_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 8;

  // Bit positions within the err vector
  localparam int ERR_W       = 4;
  localparam int ERR_IN_OVF  = 0;
  localparam int ERR_IN_UNF  = 1;
  localparam int ERR_OUT_OVF = 2;
  localparam int ERR_OUT_UNF = 3;

endpackage : io_port_pkg
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous FIFO with a registered read port. A pop returns
//               the head word one cycle later with a one-cycle rvld pulse.
//               There is no fall-through path: a pop on an empty FIFO is
//               rejected even if a push arrives in the same cycle.
// Ports       : clock, reset (sync, active-low)
//               push/wdata  - write request and data
//               pop         - read request
//               rdata/rvld  - registered read data and valid pulse
//               count       - occupancy 0..DEPTH
//               full/empty  - decoded from count
//               ovf/unf     - single-cycle pulses for a dropped push or a
//                             rejected pop
// Revision    : 1.0  initial release
// ============================================================================
module io_fifo
  import io_port_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A pop on a full FIFO frees a slot in the same cycle, so a concurrent
  // push is still accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign unf     = pop & empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
      rvld  <= 1'b0;
    end else begin
      rvld <= do_pop;
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule : io_fifo
`default_nettype wire

// File: rtl/proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : proc_io_bridge
// Description : Host-side I/O bridge for the 16-bit processor. The IN FIFO
//               carries host words to the processor din port; the OUT FIFO
//               carries processor dout words back to the host. Rejected
//               transfers are recorded in sticky error flags.
// Ports       : clock, reset (sync, active-low)
//               host_wr/host_wdata     - host push into IN
//               proc_rd -> din/din_vld - processor pop from IN
//               proc_wr/dout           - processor push into OUT
//               host_rd -> host_rdata/host_rvld - host pop from OUT
//               in_/out_ count, full, empty - FIFO status
//               err[3:0] sticky flags, err_clr clears them
// Revision    : 1.0  initial release
// ============================================================================
module proc_io_bridge
  import io_port_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             host_wr,
  input  logic [WIDTH-1:0] host_wdata,
  input  logic             proc_rd,
  output logic [WIDTH-1:0] din,
  output logic             din_vld,
  input  logic             proc_wr,
  input  logic [WIDTH-1:0] dout,
  input  logic             host_rd,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_rvld,
  output logic [AW:0]      in_count,
  output logic [AW:0]      out_count,
  output logic             in_full,
  output logic             in_empty,
  output logic             out_full,
  output logic             out_empty,
  output logic [ERR_W-1:0] err,
  input  logic             err_clr
);

  logic in_ovf;
  logic in_unf;
  logic out_ovf;
  logic out_unf;
  logic [ERR_W-1:0] new_err;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (host_wr),
    .wdata (host_wdata),
    .pop   (proc_rd),
    .rdata (din),
    .rvld  (din_vld),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty),
    .ovf   (in_ovf),
    .unf   (in_unf)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (proc_wr),
    .wdata (dout),
    .pop   (host_rd),
    .rdata (host_rdata),
    .rvld  (host_rvld),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty),
    .ovf   (out_ovf),
    .unf   (out_unf)
  );

  always_comb begin
    new_err              = '0;
    new_err[ERR_IN_OVF]  = in_ovf;
    new_err[ERR_IN_UNF]  = in_unf;
    new_err[ERR_OUT_OVF] = out_ovf;
    new_err[ERR_OUT_UNF] = out_unf;
  end

  // Clear first, then OR in this cycle's events so a fresh error survives
  // a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err <= '0;
    end else begin
      err <= (err & {ERR_W{~err_clr}}) | new_err;
    end
  end

endmodule : proc_io_bridge
`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_io_bridge
// Description : Self-checking bench for proc_io_bridge. A queue-based model
//               predicts every popped word into scoreboards that a separate
//               monitor drains on each valid pulse; counts, status flags,
//               held data and error flags are compared after every edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_proc_io_bridge;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         host_wr, proc_rd, proc_wr, host_rd, err_clr;
  logic [W-1:0] host_wdata, dout;
  logic [W-1:0] din, host_rdata;
  logic         din_vld, host_rvld;
  logic [A:0]   in_count, out_count;
  logic         in_full, in_empty, out_full, out_empty;
  logic [3:0]   err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] sb_in[$];
  logic [W-1:0] sb_out[$];
  logic [3:0]   exp_err;
  logic [W-1:0] exp_din, exp_hr;

  always #5 clk = ~clk;

  proc_io_bridge #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .proc_rd    (proc_rd),
    .din        (din),
    .din_vld    (din_vld),
    .proc_wr    (proc_wr),
    .dout       (dout),
    .host_rd    (host_rd),
    .host_rdata (host_rdata),
    .host_rvld  (host_rvld),
    .in_count   (in_count),
    .out_count  (out_count),
    .in_full    (in_full),
    .in_empty   (in_empty),
    .out_full   (out_full),
    .out_empty  (out_empty),
    .err        (err),
    .err_clr    (err_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest predicted word.
  always @(negedge clk) begin
    if (din_vld !== 1'b0) begin
      if (sb_in.size() == 0) chk("din_vld_unexpected", int'(din_vld), 0);
      else chk("din_data", int'(din), int'(sb_in.pop_front()));
    end
    if (host_rvld !== 1'b0) begin
      if (sb_out.size() == 0) chk("host_rvld_unexpected", int'(host_rvld), 0);
      else chk("host_rdata", int'(host_rdata), int'(sb_out.pop_front()));
    end
  end

  // One clock of stimulus: predict the effect, apply the edge, check state.
  task automatic cycle(input logic rs, input logic hw, input logic [W-1:0] hd,
                       input logic pr, input logic pw, input logic [W-1:0] pd,
                       input logic hr, input logic ec);
    logic [3:0] ne;
    int n;
    rst_n = rs; host_wr = hw; host_wdata = hd; proc_rd = pr;
    proc_wr = pw; dout = pd; host_rd = hr; err_clr = ec;
    ne = '0;
    if (!rs) begin
      in_q.delete(); out_q.delete();
      exp_err = '0; exp_din = '0; exp_hr = '0;
    end else begin
      // IN: pop is evaluated against the pre-edge contents, then push
      n = in_q.size();
      if (pr) begin
        if (n > 0) begin exp_din = in_q.pop_front(); sb_in.push_back(exp_din); end
        else ne[1] = 1'b1;
      end
      if (hw) begin
        if (n < D || pr) in_q.push_back(hd);
        else ne[0] = 1'b1;
      end
      // OUT
      n = out_q.size();
      if (hr) begin
        if (n > 0) begin exp_hr = out_q.pop_front(); sb_out.push_back(exp_hr); end
        else ne[3] = 1'b1;
      end
      if (pw) begin
        if (n < D || hr) out_q.push_back(pd);
        else ne[2] = 1'b1;
      end
      exp_err = (ec ? 4'h0 : exp_err) | ne;
    end
    @(posedge clk);
    #1;
    chk("in_count",   int'(in_count),   in_q.size());
    chk("out_count",  int'(out_count),  out_q.size());
    chk("in_full",    int'(in_full),    int'(in_q.size() == D));
    chk("in_empty",   int'(in_empty),   int'(in_q.size() == 0));
    chk("out_full",   int'(out_full),   int'(out_q.size() == D));
    chk("out_empty",  int'(out_empty),  int'(out_q.size() == 0));
    chk("err",        int'(err),        int'(exp_err));
    chk("din",        int'(din),        int'(exp_din));
    chk("host_rdata", int'(host_rdata), int'(exp_hr));
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_err = '0; exp_din = '0; exp_hr = '0;
    // 1. reset, then idle
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_din_vld", int'(din_vld), 0);
    chk("rst_host_rvld", int'(host_rvld), 0);
    idle();
    // 2. IN path
    cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle();
    // 3. OUT overflow, then drain
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    // 4. underflow and clear
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    // 5. simultaneous push/pop on full, then on empty
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    // 6. reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("midrst_host_rvld", int'(host_rvld), 0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    // Random traffic with phases biased towards filling or draining
    for (int i = 0; i < 600; i++) begin
      logic fill;
      fill = ((i / 40) % 2) == 0;
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) < (fill ? 3 : 1)), 16'($urandom),
            ($urandom_range(0, 3) < (fill ? 1 : 3)),
            ($urandom_range(0, 3) < (fill ? 3 : 1)), 16'($urandom),
            ($urandom_range(0, 3) < (fill ? 1 : 3)),
            ($urandom_range(0, 7) == 0));
    end
    idle();
    idle();
    chk("sb_in_leftover", sb_in.size(), 0);
    chk("sb_out_leftover", sb_out.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_proc_io_bridge
`default_nettype wire
